pattern_sequencer: RTL and testbench

- Frame-synchronous controller that selects the active test pattern for the suite video datapath.
- Merges three requesters: OSD pattern field, PS/2 keyboard next/prev, and an auto-cycle frame timer.
- Commits a new selection only on the VBlank rising edge, so the pattern generator never switches mid-frame.
- Sits between hps_io (status, ps2_key) and suite on clk_sys.

---
 rtl/pattern_seq_pkg.sv | 25 ++
 rtl/pattern_sequencer_ps2_key_decoder.sv | 51 +++++
 rtl/pattern_sequencer.sv | 132 +++++++++++++
 tb/tb_pattern_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_seq_pkg.sv
// Shared scancodes, FSM state type and index-wrap helper for the pattern sequencer.
package pattern_seq_pkg;

  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_DIGIT [1:9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                            8'h36, 8'h3D, 8'h3E, 8'h46};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } seq_state_e;

  // Step idx by +1 (dir=1) or -1 (dir=0), wrapping within 0..n-1.
  function automatic int unsigned wrap_step(input int unsigned idx, input logic dir,
                                            input int unsigned n);
    int unsigned r;
    if (dir) r = (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    else     r = (idx == 32'd0) ? n - 32'd1 : idx - 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/pattern_sequencer_ps2_key_decoder.sv
// PS/2 toggle-strobe edge detect and scancode decode into one-cycle request pulses.
// Digit direct-select decode is compiled in with PATTERN_SEQ_DIRECT_EN.
module ps2_key_decoder
  import pattern_seq_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = 8,
  parameter int unsigned PAT_W        = 4
) (
  input  logic             clk,
  input  logic [10:0]      ps2_key,
  output logic             next_c,
  output logic             prev_c,
  output logic             pause_c,
  output logic             direct_c,
  output logic [PAT_W-1:0] direct_idx_c
);

`ifdef PATTERN_SEQ_DIRECT_EN
  localparam bit DIRECT_EN = 1'b1;
`else
  localparam bit DIRECT_EN = 1'b0;
`endif

  logic       tog_q;
  logic       press_c;
  logic       ext_c;
  logic [7:0] sc_c;

  // Copy tracks the strobe every cycle, reset included, so a dropped event is never replayed.
  always_ff @(posedge clk) begin
    tog_q <= ps2_key[10];
  end

  always_comb begin
    press_c      = (ps2_key[10] != tog_q) && ps2_key[9];
    ext_c        = ps2_key[8];
    sc_c         = ps2_key[7:0];
    next_c       = press_c && ext_c && (sc_c == SC_RIGHT);
    prev_c       = press_c && ext_c && (sc_c == SC_LEFT);
    pause_c      = press_c && !ext_c && (sc_c == SC_SPACE);
    direct_c     = 1'b0;
    direct_idx_c = '0;
    for (int unsigned d = 1; d <= 9; d++) begin
      if (DIRECT_EN && press_c && !ext_c && (sc_c == SC_DIGIT[d]) && (d <= NUM_PATTERNS)) begin
        direct_c     = 1'b1;
        direct_idx_c = PAT_W'(d - 1);
      end
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Frame-synchronous test-pattern selector: merges OSD, keyboard and auto-cycle requests
// and commits on VBlank rise. Optional digit direct-select: PATTERN_SEQ_DIRECT_EN.
module pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = 8,
  parameter int unsigned PAT_W        = 4,
  parameter int unsigned FRAME_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vblank,
  input  logic [10:0]        ps2_key,
  input  logic [PAT_W-1:0]   osd_sel,
  input  logic               auto_en,
  input  logic [FRAME_W-1:0] auto_frames,
  output logic [PAT_W-1:0]   pattern_sel,
  output logic               sel_strobe,
  output logic               pending,
  output logic               paused
);

  localparam logic [PAT_W-1:0] LAST_IDX = PAT_W'(NUM_PATTERNS - 1);

  seq_state_e         state_q, state_d;
  logic               vblank_q;
  logic [PAT_W-1:0]   osd_q;
  logic [PAT_W-1:0]   target_q, target_d;
  logic [PAT_W-1:0]   pattern_sel_q, pattern_sel_d;
  logic               sel_strobe_q, sel_strobe_d;
  logic               pending_q, pending_d;
  logic               paused_q, paused_d;
  logic [FRAME_W-1:0] cnt_q, cnt_d;

  logic               next_c, prev_c, pause_c, direct_c;
  logic [PAT_W-1:0]   direct_idx_c;
  logic               rise_c, osd_evt_c, key_any_c, sel_evt_c, auto_evt_c, cnt_hit_c;
  logic [FRAME_W-1:0] lim_m1_c;
  logic [PAT_W-1:0]   osd_clamp_c, base_c;

  ps2_key_decoder #(
    .NUM_PATTERNS (NUM_PATTERNS),
    .PAT_W        (PAT_W)
  ) u_key_dec (
    .clk          (clk),
    .ps2_key      (ps2_key),
    .next_c       (next_c),
    .prev_c       (prev_c),
    .pause_c      (pause_c),
    .direct_c     (direct_c),
    .direct_idx_c (direct_idx_c)
  );

  // Event qualification with OSD > key > auto priority.
  always_comb begin
    rise_c      = vblank && !vblank_q;
    osd_evt_c   = (osd_sel != osd_q);
    osd_clamp_c = (osd_sel > LAST_IDX) ? LAST_IDX : osd_sel;
    key_any_c   = next_c || prev_c || pause_c || direct_c;
    lim_m1_c    = (auto_frames == '0) ? '0 : auto_frames - FRAME_W'(1);
    cnt_hit_c   = (cnt_q == lim_m1_c);
    auto_evt_c  = rise_c && auto_en && !paused_q && cnt_hit_c && !osd_evt_c && !key_any_c;
    sel_evt_c   = osd_evt_c || next_c || prev_c || direct_c || auto_evt_c;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; COMMIT accepts new events exactly like IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PENDING: if (rise_c) state_d = COMMIT;
      IDLE, COMMIT: begin
        if (auto_evt_c)     state_d = COMMIT;
        else if (sel_evt_c) state_d = PENDING;
        else                state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Target stepping and next values of all registered outputs.
  always_comb begin
    base_c   = (state_q == PENDING) ? target_q : pattern_sel_q;
    target_d = base_c;
    if (osd_evt_c)       target_d = osd_clamp_c;
    else if (direct_c)   target_d = direct_idx_c;
    else if (next_c)     target_d = PAT_W'(wrap_step(32'(base_c), 1'b1, NUM_PATTERNS));
    else if (prev_c)     target_d = PAT_W'(wrap_step(32'(base_c), 1'b0, NUM_PATTERNS));
    else if (auto_evt_c) target_d = PAT_W'(wrap_step(32'(base_c), 1'b1, NUM_PATTERNS));

    pattern_sel_d = (state_d == COMMIT) ? target_d : pattern_sel_q;
    sel_strobe_d  = (state_d == COMMIT);
    pending_d     = (state_d == PENDING);
    paused_d      = paused_q ^ (pause_c && !osd_evt_c);

    if (!auto_en || state_q == COMMIT) cnt_d = '0;
    else if (rise_c && !paused_q)      cnt_d = cnt_hit_c ? '0 : cnt_q + FRAME_W'(1);
    else                               cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_q      <= 1'b0;
      osd_q         <= osd_sel;
      target_q      <= '0;
      pattern_sel_q <= '0;
      sel_strobe_q  <= 1'b0;
      pending_q     <= 1'b0;
      paused_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      vblank_q      <= vblank;
      osd_q         <= osd_sel;
      target_q      <= target_d;
      pattern_sel_q <= pattern_sel_d;
      sel_strobe_q  <= sel_strobe_d;
      pending_q     <= pending_d;
      paused_q      <= paused_d;
      cnt_q         <= cnt_d;
    end
  end

  assign pattern_sel = pattern_sel_q;
  assign sel_strobe  = sel_strobe_q;
  assign pending     = pending_q;
  assign paused      = paused_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with a per-cycle reference model and literal checkpoints.
module tb_pattern_sequencer;

  localparam int unsigned N  = 8;
  localparam int unsigned PW = 4;
  localparam int unsigned FW = 8;

`ifdef PATTERN_SEQ_DIRECT_EN
  localparam bit DIRECT = 1'b1;
`else
  localparam bit DIRECT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          vblank;
  logic [10:0]   ps2_key;
  logic [PW-1:0] osd_sel;
  logic          auto_en;
  logic [FW-1:0] auto_frames;
  logic [PW-1:0] pattern_sel;
  logic          sel_strobe;
  logic          pending;
  logic          paused;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pattern_sequencer #(
    .NUM_PATTERNS (N),
    .PAT_W        (PW),
    .FRAME_W      (FW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vblank      (vblank),
    .ps2_key     (ps2_key),
    .osd_sel     (osd_sel),
    .auto_en     (auto_en),
    .auto_frames (auto_frames),
    .pattern_sel (pattern_sel),
    .sel_strobe  (sel_strobe),
    .pending     (pending),
    .paused      (paused)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_sel, m_tgt, m_cnt;
  bit            m_pend, m_strobe, m_paused, m_vb_prev, m_tog, m_valid;
  logic [PW-1:0] m_osd;

  function automatic int digit_of(input logic [7:0] sc);
    case (sc)
      8'h16: return 1;
      8'h1E: return 2;
      8'h26: return 3;
      8'h25: return 4;
      8'h2E: return 5;
      8'h36: return 6;
      8'h3D: return 7;
      8'h3E: return 8;
      8'h46: return 9;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    int lim, base, t, dig;
    bit rise, osd, kev, nxt, prv, spc, dsel, keyany, autoe, req, commit, old_strobe, old_paused;
    if (reset) begin
      m_sel = 0; m_tgt = 0; m_cnt = 0;
      m_pend = 0; m_strobe = 0; m_paused = 0; m_vb_prev = 0;
      m_tog = ps2_key[10]; m_osd = osd_sel; m_valid = 1;
    end else begin
      rise   = vblank && !m_vb_prev;
      osd    = (osd_sel != m_osd);
      kev    = (ps2_key[10] != m_tog) && ps2_key[9];
      nxt    = kev && ps2_key[8] && ps2_key[7:0] == 8'h74;
      prv    = kev && ps2_key[8] && ps2_key[7:0] == 8'h6B;
      spc    = kev && !ps2_key[8] && ps2_key[7:0] == 8'h29;
      dig    = digit_of(ps2_key[7:0]);
      dsel   = DIRECT && kev && !ps2_key[8] && dig >= 1 && dig <= int'(N);
      keyany = nxt || prv || spc || dsel;
      lim    = (auto_frames == 0) ? 1 : int'(auto_frames);
      autoe  = rise && auto_en && !m_paused && (m_cnt == lim - 1) && !osd && !keyany;
      base   = m_pend ? m_tgt : m_sel;
      t      = base;
      req    = 1;
      if (osd)        t = (int'(osd_sel) >= int'(N)) ? int'(N) - 1 : int'(osd_sel);
      else if (dsel)  t = dig - 1;
      else if (nxt)   t = (base + 1) % int'(N);
      else if (prv)   t = (base + int'(N) - 1) % int'(N);
      else if (autoe) t = (base + 1) % int'(N);
      else            req = 0;
      old_strobe = m_strobe;
      old_paused = m_paused;
      if (spc && !osd) m_paused = !m_paused;
      if (!auto_en || old_strobe)    m_cnt = 0;
      else if (rise && !old_paused)  m_cnt = (m_cnt == lim - 1) ? 0 : (m_cnt + 1) % 256;
      commit   = m_pend ? rise : autoe;
      m_strobe = 0;
      if (commit) begin
        m_sel = t; m_strobe = 1; m_pend = 0;
      end else if (req) begin
        m_tgt = t; m_pend = 1;
      end
      m_tog     = ps2_key[10];
      m_osd     = osd_sel;
      m_vb_prev = vblank;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_sel",     32'(pattern_sel), 32'(m_sel));
      check("model_strobe",  32'(sel_strobe),  32'(m_strobe));
      check("model_pending", 32'(pending),     32'(m_pend));
      check("model_paused",  32'(paused),      32'(m_paused));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic ext, input logic [7:0] sc, input logic pr);
    ps2_key = {~ps2_key[10], pr, ext, sc};
    tick(1);
  endtask

  task automatic low(input int n);
    vblank = 1'b0;
    tick(n);
  endtask

  task automatic rise();
    vblank = 1'b1;
    tick(1);
  endtask

  initial begin
    int exp_sel;
    reset = 1'b1; vblank = 1'b0; ps2_key = '0; osd_sel = '0;
    auto_en = 1'b0; auto_frames = 8'd2;
    tick(3);
    check("rst_sel",     32'(pattern_sel), 0);
    check("rst_strobe",  32'(sel_strobe),  0);
    check("rst_pending", 32'(pending),     0);
    check("rst_paused",  32'(paused),      0);
    reset = 1'b0;

    // Right arrow mid-frame: pending until the vblank rise, then commit 1.
    low(5);
    press(1'b1, 8'h74, 1'b1);
    check("r1_pending", 32'(pending), 1);
    tick(10);
    check("r1_hold_sel", 32'(pattern_sel), 0);
    rise();
    check("r1_strobe", 32'(sel_strobe), 1);
    check("r1_sel",    32'(pattern_sel), 1);
    tick(1);
    check("r1_strobe_off", 32'(sel_strobe), 0);
    tick(2);

    // Request while vblank already high waits for the next rise.
    press(1'b1, 8'h74, 1'b1);
    tick(2);
    low(20);
    check("vbh_pending", 32'(pending), 1);
    check("vbh_sel",     32'(pattern_sel), 1);
    rise();
    check("vbh_commit", 32'(pattern_sel), 2);
    tick(4);

    // Back to 0, then three lefts (with a release and an unlisted key) accumulate to 5.
    low(5);
    press(1'b1, 8'h6B, 1'b1);
    press(1'b1, 8'h6B, 1'b1);
    rise();
    check("left_to0", 32'(pattern_sel), 0);
    tick(4);
    low(5);
    press(1'b1, 8'h6B, 1'b1);
    press(1'b1, 8'h6B, 1'b0);
    press(1'b0, 8'h1C, 1'b1);
    press(1'b1, 8'h6B, 1'b1);
    press(1'b1, 8'h6B, 1'b1);
    low(10);
    rise();
    check("left3_strobe", 32'(sel_strobe), 1);
    check("left3_sel",    32'(pattern_sel), 5);
    tick(4);

    // OSD and right arrow same cycle: OSD wins, key not replayed.
    low(5);
    osd_sel = 4'd3;
    ps2_key = {~ps2_key[10], 1'b1, 1'b1, 8'h74};
    tick(1);
    check("osd_pending", 32'(pending), 1);
    low(10);
    rise();
    check("osd_sel3", 32'(pattern_sel), 3);
    tick(4);
    low(20);
    rise();
    check("osd_noreplay_strobe", 32'(sel_strobe), 0);
    check("osd_noreplay_sel",    32'(pattern_sel), 3);
    tick(4);

    // OSD out of range clamps to the last pattern.
    low(5);
    osd_sel = 4'd12;
    low(5);
    rise();
    check("osd_clamp", 32'(pattern_sel), 7);
    tick(4);

    // Reset while pending with target 4 discards the request.
    low(5);
    osd_sel = 4'd4;
    tick(1);
    check("rstp_pending", 32'(pending), 1);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rstp_sel",     32'(pattern_sel), 0);
    check("rstp_pending", 32'(pending), 0);
    low(10);
    rise();
    check("rstp_nostrobe", 32'(sel_strobe), 0);
    check("rstp_sel_vb",   32'(pattern_sel), 0);
    tick(4);

    // Digit keys: direct select when enabled, ignored otherwise.
    exp_sel = DIRECT ? 5 : 0;
    low(5);
    press(1'b0, 8'h36, 1'b1);
    check("dig6_pending", 32'(pending), 32'(DIRECT));
    low(5);
    rise();
    check("dig6_sel", 32'(pattern_sel), 32'(exp_sel));
    tick(4);
    low(5);
    press(1'b0, 8'h46, 1'b1);
    check("dig9_pending", 32'(pending), 0);
    low(5);
    rise();
    check("dig9_strobe", 32'(sel_strobe), 0);
    check("dig9_sel",    32'(pattern_sel), 32'(exp_sel));
    tick(4);

    // Return to 0 via OSD, then auto-cycle every 2nd rise.
    low(5);
    osd_sel = 4'd0;
    low(5);
    rise();
    check("auto_start", 32'(pattern_sel), 0);
    tick(4);
    auto_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      low(20);
      rise();
      check("auto_seq", 32'(pattern_sel), 32'((k / 2) % 8));
      tick(4);
    end

    // Space pauses for 10 frames, second space resumes.
    low(5);
    press(1'b0, 8'h29, 1'b1);
    check("pause_on", 32'(paused), 1);
    for (int k = 0; k < 10; k++) begin
      low(20);
      rise();
      check("pause_hold", 32'(pattern_sel), 0);
      tick(4);
    end
    low(5);
    press(1'b0, 8'h29, 1'b1);
    check("pause_off", 32'(paused), 0);
    for (int k = 1; k <= 2; k++) begin
      low(20);
      rise();
      check("resume_seq", 32'(pattern_sel), 32'(k / 2));
      tick(4);
    end

    // auto_frames=0 behaves as 1: advance every rise.
    auto_frames = 8'd0;
    for (int k = 1; k <= 3; k++) begin
      low(20);
      rise();
      check("af0_seq", 32'(pattern_sel), 32'(1 + k));
      tick(4);
    end

    auto_en = 1'b0;
    low(20);
    rise();
    check("auto_off_hold", 32'(pattern_sel), 4);
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
